// File: rtl/traffic_light_monitor.sv
// Receive-side checker for the one-hot traffic light bus: tracks phase and dwell,
// flags encoding/order/duration errors. Optional cycle counter: TRAFFIC_LIGHT_MONITOR_CYCLE_CNT_EN.
module traffic_light_monitor #(
    parameter int CNT_W  = 7,
    parameter int ERRC_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        light,
    input  logic [17:0]       timer_config,
    input  logic              clr_err,
    output logic [2:0]        phase,
    output logic [CNT_W-1:0]  dwell_cnt,
    output logic              dwell_valid,
    output logic [2:0]        last_phase,
    output logic [CNT_W-1:0]  last_dwell,
    output logic              err_encoding,
    output logic              err_sequence,
    output logic              err_duration,
    output logic              err_sticky,
    output logic [ERRC_W-1:0] err_count,
    output logic [15:0]       cycle_count
);

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    typedef enum logic {
        SYNC  = 1'b0,
        TRACK = 1'b1
    } fsm_e;

    function automatic logic is_legal(input logic [2:0] l);
        return (l == RED) || (l == YEL) || (l == GRN);
    endfunction

    function automatic logic order_ok(input logic [2:0] from_p, input logic [2:0] to_p);
        case (from_p)
            RED:     return to_p == GRN;
            GRN:     return to_p == YEL;
            YEL:     return to_p == RED;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [5:0] cfg_field(input logic [2:0] p, input logic [17:0] cfg);
        case (p)
            RED:     return cfg[17:12];
            YEL:     return cfg[11:6];
            default: return cfg[5:0];
        endcase
    endfunction

    fsm_e              fsm_q;
    logic [2:0]        phase_q;
    logic [CNT_W-1:0]  dwell_q;
    logic [CNT_W-1:0]  exp_q;
    logic              overrun_q;
    logic              illegal_q;
    logic              dwell_valid_q;
    logic [2:0]        last_phase_q;
    logic [CNT_W-1:0]  last_dwell_q;
    logic              err_enc_q;
    logic              err_seq_q;
    logic              err_dur_q;
    logic              err_sticky_q;
    logic [ERRC_W-1:0] err_count_q;

    logic              legal_s;
    logic              boundary_s;
    logic              same_s;
    logic              resync_s;
    logic              enc_s;
    logic              seq_s;
    logic              dur_s;
    logic              any_err_s;
    logic [CNT_W-1:0]  exp_next_s;
    logic [ERRC_W-1:0] err_count_d;
    logic              err_sticky_d;

    // Classify the current light sample against the tracked phase.
    always_comb begin
        legal_s    = is_legal(light);
        boundary_s = legal_s && (light != phase_q);
        same_s     = legal_s && (light == phase_q);
        resync_s   = boundary_s && illegal_q;
        enc_s      = !legal_s;
        seq_s      = boundary_s && !resync_s && !order_ok(phase_q, light);
        // Short phase at the boundary, or overrun reached while still holding; once per phase.
        dur_s      = (fsm_q == TRACK) && !overrun_q &&
                     ((boundary_s && (dwell_q < exp_q)) ||
                      (same_s && (dwell_q == exp_q)));
        any_err_s  = enc_s || seq_s || dur_s;
        exp_next_s = CNT_W'(cfg_field(light, timer_config)) + CNT_W'(1);
    end

    // Error bookkeeping: a fresh error outranks a same-cycle clear.
    always_comb begin
        err_count_d  = err_count_q;
        err_sticky_d = err_sticky_q;
        if (any_err_s) begin
            err_sticky_d = 1'b1;
            if (clr_err) begin
                err_count_d = {{(ERRC_W-1){1'b0}}, 1'b1};
            end else if (err_count_q != {ERRC_W{1'b1}}) begin
                err_count_d = err_count_q + ERRC_W'(1);
            end else begin
                err_count_d = err_count_q;
            end
        end else if (clr_err) begin
            err_sticky_d = 1'b0;
            err_count_d  = '0;
        end else begin
            err_sticky_d = err_sticky_q;
            err_count_d  = err_count_q;
        end
    end

    // Phase tracking FSM with registered status and error pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fsm_q         <= SYNC;
            phase_q       <= RED;
            dwell_q       <= '0;
            exp_q         <= '0;
            overrun_q     <= 1'b0;
            illegal_q     <= 1'b0;
            dwell_valid_q <= 1'b0;
            last_phase_q  <= RED;
            last_dwell_q  <= '0;
            err_enc_q     <= 1'b0;
            err_seq_q     <= 1'b0;
            err_dur_q     <= 1'b0;
            err_sticky_q  <= 1'b0;
            err_count_q   <= '0;
        end else begin
            dwell_valid_q <= boundary_s;
            err_enc_q     <= enc_s;
            err_seq_q     <= seq_s;
            err_dur_q     <= dur_s;
            err_sticky_q  <= err_sticky_d;
            err_count_q   <= err_count_d;
            illegal_q     <= !legal_s;
            if (!legal_s) begin
                fsm_q <= SYNC;
            end else if (boundary_s) begin
                last_phase_q <= phase_q;
                last_dwell_q <= dwell_q;
                phase_q      <= light;
                dwell_q      <= CNT_W'(1);
                exp_q        <= exp_next_s;
                overrun_q    <= 1'b0;
                // After an illegal gap the new phase start is untrusted.
                fsm_q        <= resync_s ? SYNC : TRACK;
            end else begin
                if (dwell_q != {CNT_W{1'b1}}) begin
                    dwell_q <= dwell_q + CNT_W'(1);
                end
                if (dur_s) begin
                    overrun_q <= 1'b1;
                end
            end
        end
    end

`ifdef TRAFFIC_LIGHT_MONITOR_CYCLE_CNT_EN
    logic        cyc_ok_q;
    logic [15:0] cycle_q;
    logic        into_red_s;
    logic        y_to_r_s;

    // Boundary kinds relevant to full-cycle counting.
    always_comb begin
        into_red_s = boundary_s && (light == RED);
        y_to_r_s   = into_red_s && !resync_s && (phase_q == YEL);
    end

    // A full R->G->Y cycle counts when its R start was tracked and it stayed error-free.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cyc_ok_q <= 1'b0;
            cycle_q  <= '0;
        end else begin
            if (y_to_r_s && cyc_ok_q && !any_err_s && (cycle_q != 16'hFFFF)) begin
                cycle_q <= cycle_q + 16'd1;
            end
            if (into_red_s) begin
                cyc_ok_q <= !resync_s;
            end else if (any_err_s) begin
                cyc_ok_q <= 1'b0;
            end
        end
    end

    assign cycle_count = cycle_q;
`else
    assign cycle_count = 16'h0000;
`endif

    assign phase        = phase_q;
    assign dwell_cnt    = dwell_q;
    assign dwell_valid  = dwell_valid_q;
    assign last_phase   = last_phase_q;
    assign last_dwell   = last_dwell_q;
    assign err_encoding = err_enc_q;
    assign err_sequence = err_seq_q;
    assign err_duration = err_dur_q;
    assign err_sticky   = err_sticky_q;
    assign err_count    = err_count_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed self-checking bench for traffic_light_monitor (cfg R=3, Y=1, G=2).
module tb_traffic_light_monitor;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;
`ifdef TRAFFIC_LIGHT_MONITOR_CYCLE_CNT_EN
    localparam int EXP_CYC = 1;
`else
    localparam int EXP_CYC = 0;
`endif

    logic        clk;
    logic        reset;
    logic [2:0]  light;
    logic [17:0] timer_config;
    logic        clr_err;
    logic [2:0]  phase;
    logic [6:0]  dwell_cnt;
    logic        dwell_valid;
    logic [2:0]  last_phase;
    logic [6:0]  last_dwell;
    logic        err_encoding;
    logic        err_sequence;
    logic        err_duration;
    logic        err_sticky;
    logic [7:0]  err_count;
    logic [15:0] cycle_count;

    int n_chk;
    int n_fail;

    traffic_light_monitor #(.CNT_W(7), .ERRC_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .light        (light),
        .timer_config (timer_config),
        .clr_err      (clr_err),
        .phase        (phase),
        .dwell_cnt    (dwell_cnt),
        .dwell_valid  (dwell_valid),
        .last_phase   (last_phase),
        .last_dwell   (last_dwell),
        .err_encoding (err_encoding),
        .err_sequence (err_sequence),
        .err_duration (err_duration),
        .err_sticky   (err_sticky),
        .err_count    (err_count),
        .cycle_count  (cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [2:0] l);
        light = l;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_err(input string tag, input logic [2:0] exp);
        chk(tag, {29'd0, err_encoding, err_sequence, err_duration}, {29'd0, exp});
    endtask

    task automatic chk_bnd(input string tag, input logic [2:0] lp, input logic [6:0] ld);
        chk({tag, "_valid"}, dwell_valid, 1);
        chk({tag, "_lphase"}, last_phase, lp);
        chk({tag, "_ldwell"}, last_dwell, ld);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_phase"}, phase, R);
        chk({tag, "_dwell"}, dwell_cnt, 0);
        chk({tag, "_valid"}, dwell_valid, 0);
        chk({tag, "_lphase"}, last_phase, R);
        chk({tag, "_ldwell"}, last_dwell, 0);
        chk_err({tag, "_errs"}, 3'b000);
        chk({tag, "_sticky"}, err_sticky, 0);
        chk({tag, "_count"}, err_count, 0);
        chk({tag, "_cycles"}, cycle_count, 0);
    endtask

    initial begin
        n_chk        = 0;
        n_fail       = 0;
        reset        = 1'b0;
        light        = R;
        clr_err      = 1'b0;
        timer_config = {6'd3, 6'd1, 6'd2};
        repeat (3) @(posedge clk);
        #1;
        chk_reset_state("rst");
        reset = 1'b1;

        // Normal cycles: R(1) G3 Y2 R4 G3 Y2 R
        step(R);
        chk("t1_dwell_r1", dwell_cnt, 1);
        chk("t1_novalid", dwell_valid, 0);
        step(G);
        chk_bnd("t1_rg", R, 1);
        chk_err("t1_rg_err", 3'b000);
        chk("t1_phase_g", phase, G);
        step(G); step(G);
        chk("t1_dwell_g3", dwell_cnt, 3);
        step(Y);
        chk_bnd("t1_gy", G, 3);
        chk_err("t1_gy_err", 3'b000);
        step(Y); step(R);
        chk_bnd("t1_yr", Y, 2);
        chk_err("t1_yr_err", 3'b000);
        repeat (3) step(R);
        chk("t1_dwell_r4", dwell_cnt, 4);
        step(G);
        chk_bnd("t1_rg2", R, 4);
        chk_err("t1_rg2_err", 3'b000);
        step(G); step(G); step(Y);
        chk_bnd("t1_gy2", G, 3);
        step(Y); step(R);
        chk_bnd("t1_yr2", Y, 2);
        chk_err("t1_yr2_err", 3'b000);
        chk("t1_cycles", cycle_count, EXP_CYC);
        chk("t1_count", err_count, 0);
        chk("t1_sticky", err_sticky, 0);

        // Short green: G held 2 cycles
        repeat (3) step(R);
        step(G);
        chk_err("t2_rg_err", 3'b000);
        step(G); step(Y);
        chk_err("t2_short_g", 3'b001);
        chk_bnd("t2_gy", G, 2);
        chk("t2_count", err_count, 1);
        chk("t2_sticky", err_sticky, 1);
        step(Y);
        chk_err("t2_pulse_end", 3'b000);
        step(R);
        chk_err("t2_yr_err", 3'b000);
        chk_bnd("t2_yr", Y, 2);

        // Overrun: G held 5 cycles
        repeat (3) step(R);
        step(G); step(G); step(G);
        chk_err("t3_g3_ok", 3'b000);
        chk("t3_dwell3", dwell_cnt, 3);
        step(G);
        chk_err("t3_overrun", 3'b001);
        chk("t3_dwell4", dwell_cnt, 4);
        step(G);
        chk_err("t3_once", 3'b000);
        step(Y);
        chk_err("t3_gy_noerr", 3'b000);
        chk_bnd("t3_gy", G, 5);
        chk("t3_count", err_count, 2);
        chk("t3_cycles", cycle_count, EXP_CYC);

        // Out-of-order R->Y, then short checked Y
        step(Y); step(R);
        chk_err("t4_yr_ok", 3'b000);
        repeat (3) step(R);
        step(Y);
        chk_err("t4_ry_seq", 3'b010);
        chk("t4_phase_y", phase, Y);
        chk_bnd("t4_ry", R, 4);
        step(R);
        chk_err("t4_y_short", 3'b001);
        chk_bnd("t4_yr", Y, 1);
        chk("t4_count", err_count, 4);

        // Illegal encoding, resync into unchecked G, then checked Y
        repeat (3) step(R);
        step(3'b110);
        chk_err("t5_enc1", 3'b100);
        chk("t5_phase_hold", phase, R);
        chk("t5_dwell_hold", dwell_cnt, 4);
        chk("t5_novalid", dwell_valid, 0);
        step(3'b110);
        chk_err("t5_enc2", 3'b100);
        step(G);
        chk_err("t5_resync", 3'b000);
        chk_bnd("t5_rg", R, 4);
        chk("t5_count", err_count, 6);
        step(Y);
        chk_err("t5_g_unchecked", 3'b000);
        chk_bnd("t5_gy", G, 1);
        step(R);
        chk_err("t5_y_checked", 3'b001);
        chk("t5_count2", err_count, 7);

        // Saturation and clear
        repeat (300) step(3'b000);
        chk_err("t6_enc", 3'b100);
        chk("t6_sat", err_count, 255);
        chk("t6_sticky", err_sticky, 1);
        clr_err = 1'b1;
        step(R);
        chk("t6_clr_count", err_count, 0);
        chk("t6_clr_sticky", err_sticky, 0);
        chk_err("t6_clr_errs", 3'b000);
        chk("t6_dwell", dwell_cnt, 2);
        step(3'b000);
        chk("t6_win_count", err_count, 1);
        chk("t6_win_sticky", err_sticky, 1);
        clr_err = 1'b0;
        step(G);
        chk_err("t6_resync", 3'b000);
        step(G);
        chk("t6_dwell_g2", dwell_cnt, 2);

        // Asynchronous reset mid-phase
        #3 reset = 1'b0;
        #1;
        chk_reset_state("arst");
        step(G);
        chk("arst_hold_phase", phase, R);
        reset = 1'b1;
        step(R);
        chk("arst_post_dwell", dwell_cnt, 1);
        chk("arst_post_valid", dwell_valid, 0);
        chk_err("arst_post_errs", 3'b000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/traffic_light_monitor.md
Name: traffic_light_monitor

Overview:
- Receive-side checker for the 3-bit one-hot traffic light bus (RED=3'b100, YELLOW=3'b010, GREEN=3'b001) and its 18-bit timer_config (RRRRRR|YYYYYY|GGGGGG).
- Tracks the displayed phase and measures the dwell of each phase in cycles.
- Flags illegal encodings, illegal phase order, and dwell mismatches against config.
- Sits beside the light controller in the intersection subsystem; feeds status and debug logic.

Parameters:
- CNT_W, 7, dwell counter width. Must be >= 7 so it can hold 64, the maximum legal dwell.
- ERRC_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- light  in  3  observed light bus
- timer_config  in  18  phase durations {R,Y,G}, 6 bits each
- clr_err  in  1  synchronous clear of err_sticky and err_count
- phase  out  3  registered copy of the last legal light value
- dwell_cnt  out  CNT_W  cycles the current phase has been held
- dwell_valid  out  1  1-cycle pulse: a phase just ended
- last_phase  out  3  phase that just ended; valid with dwell_valid
- last_dwell  out  CNT_W  length of that phase in cycles; valid with dwell_valid
- err_encoding  out  1  pulse: light not one-hot-legal
- err_sequence  out  1  pulse: illegal transition
- err_duration  out  1  pulse: phase too short or overran
- err_sticky  out  1  OR of all error pulses since reset/clear
- err_count  out  ERRC_W  saturating count of cycles with any error pulse
- cycle_count  out  16  see Optional Feature

Behaviour:
- Reset values (reset low):
  - phase=3'b100; dwell_cnt=0; last_phase=3'b100; last_dwell=0.
  - All pulses 0; err_sticky=0; err_count=0; cycle_count=0.
  - FSM=SYNC.
- FSM states: SYNC (no duration knowledge) and TRACK (current phase start observed).
- Expected dwell for phase P = cfg field(P)+1 cycles.
  - The field is latched into exp_dwell at the boundary edge that enters P.
  - timer_config must be static within a phase.
- Every edge, light is compared with phase:
  - Illegal light (not R/Y/G):
    - err_encoding=1 next cycle; FSM->SYNC.
    - phase and dwell_cnt hold.
    - Repeats every cycle while illegal.
  - Legal and equal to phase: dwell_cnt increments, saturating at all-ones.
  - Legal and different from phase (boundary):
    - dwell_valid=1; last_phase=phase; last_dwell=dwell_cnt.
    - phase=light; dwell_cnt=1; exp_dwell latched.
    - If reached from a preceding illegal value: treated as a resync, with no sequence or duration check.
    - Otherwise check order R->G, G->Y, Y->R; any other order gives err_sequence=1.
    - FSM->TRACK.
- Duration checks apply only while FSM=TRACK before the boundary edge:
  - Short: boundary with last_dwell < exp_dwell gives err_duration=1.
  - Overrun: non-boundary edge with dwell_cnt == exp_dwell gives err_duration=1, once per phase. A later boundary of that phase raises no second duration error.
- First phase after reset or after resync is unchecked; SYNC never produces err_duration.
- All outputs are registered; every pulse appears in the cycle after the edge that detected it.
- Error counting:
  - err_count += 1 on any cycle with ≥1 error pulse; saturates at 2^ERRC_W-1.
  - err_sticky sets on any pulse.
- clr_err: clears err_sticky and err_count; an error pulse in the same cycle wins (sticky=1, count=1).
- Reset asserted mid-phase returns to reset values immediately; no pulses are generated for the aborted phase.

Optional Feature:
- Macro: TRAFFIC_LIGHT_MONITOR_CYCLE_CNT_EN.
- Defined: cycle_count increments (saturating at 16'hFFFF) on each Y->R boundary, provided all of the following hold:
  - the R, G and Y phases just completed were all tracked;
  - no error pulse occurred since the previous R start.
- Counted cycles are sampled at the edge of that Y->R boundary.
- Not defined: cycle_count tied to 0; no counter logic.

Test Plan:
- cfg R=3,Y=1,G=2; drive R(1),G×3,Y×2,R×4,G×3 cycles -> dwell_valid pulses with last_dwell 1(R, unchecked),3(G),2(Y),4(R); no errors. With macro: cycle_count=1 after second Y->R.
- Same cfg, G held 2 cycles then Y -> err_duration pulse one cycle after the G->Y boundary; err_count=1; err_sticky=1.
- Same cfg, G held 5 cycles -> err_duration once, after the 3rd G cycle; no second error at the G->Y boundary; last_dwell=5.
- Transition R->Y -> err_sequence=1; phase=Y; FSM TRACK; following Y dwell is duration-checked.
- light=3'b110 for 2 cycles then G -> err_encoding pulses twice; err_count=2; the following G phase is unchecked; its Y->R boundary is checked normally.
- Force 300 error cycles, then assert clr_err with no error -> err_count saturates at 255, then reads 0; err_sticky=0; async reset mid-phase returns all outputs to reset values.
